// File: rtl/sram_ctrl_if.sv
// Client-side request/acknowledge bus for the SRAM controller.
interface sram_ctrl_if #(
  parameter int AW = 17,
  parameter int DW = 16,
  parameter int BW = DW / 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [BW-1:0] be;
  logic          ready;
  logic          ack;
  logic [DW-1:0] dout;

  modport master (output req, we, addr, din, be, input ready, ack, dout);
  modport slave  (input req, we, addr, din, be, output ready, ack, dout);
endinterface

// File: rtl/sram_ctrl_sync.sv
// Registered req/ack controller for an external asynchronous SRAM with
// programmable read strobe and write pulse widths.
//
// state     | meaning
// IDLE      | pins parked, ready for a request
// RD_STROBE | oe_n low for RD_WAIT cycles, data sampled on the last edge
// WR_SETUP  | address/data/byte masks driven, we_n still high
// WR_PULSE  | we_n low for WR_WAIT cycles
// WR_HOLD   | we_n high, data still driven, ack returned
module sram_ctrl_sync #(
  parameter int AW      = 17,
  parameter int DW      = 16,
  parameter int BW      = DW / 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  sram_ctrl_if.slave    bus,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_dq,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  output logic [BW-1:0] sram_be_n
);

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept;
  logic          rd_done;
  logic          wr_nx;
  logic [BW-1:0] be_nx;

  logic [AW-1:0] addr_r;
  logic [DW-1:0] din_r;
  logic [BW-1:0] be_r;
  logic          dq_oe;
  logic          ack_r;
  logic [DW-1:0] dout_r;

  assign bus.ready = (state == IDLE) & ~reset;
  assign bus.ack   = ack_r;
  assign bus.dout  = dout_r;
  assign sram_addr = addr_r;
  assign sram_dq   = dq_oe ? din_r : {DW{1'bz}};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    rd_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept   = 1'b1;
          state_nx = bus.we ? WR_SETUP : RD_STROBE;
          cnt_nx   = CW'(RD_WAIT - 1);
        end
      end
      RD_STROBE: begin
        if (cnt == '0) begin
          rd_done  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      WR_SETUP: begin
        state_nx = WR_PULSE;
        cnt_nx   = CW'(WR_WAIT - 1);
      end
      WR_PULSE: begin
        if (cnt == '0) state_nx = WR_HOLD;
        else           cnt_nx   = cnt - CW'(1);
      end
      WR_HOLD: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte masks for a write must come straight from the bus on the accepting
  // edge, since be_r is only being captured at that same edge.
  assign be_nx = accept ? bus.be : be_r;
  assign wr_nx = (state_nx == WR_SETUP) | (state_nx == WR_PULSE) | (state_nx == WR_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_r    <= '0;
      din_r     <= '0;
      be_r      <= '0;
      dq_oe     <= 1'b0;
      ack_r     <= 1'b0;
      dout_r    <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_be_n <= '1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_r <= bus.addr;
        din_r  <= bus.din;
        be_r   <= bus.be;
      end
      if (rd_done) dout_r <= sram_dq;
      ack_r     <= rd_done | (state_nx == WR_HOLD);
      sram_oe_n <= (state_nx != RD_STROBE);
      sram_we_n <= (state_nx != WR_PULSE);
      dq_oe     <= wr_nx;
      if (state_nx == RD_STROBE) sram_be_n <= '0;
      else if (wr_nx)            sram_be_n <= ~be_nx;
      else                       sram_be_n <= '1;
    end
  end

endmodule

// File: doc/sram_ctrl_sync.md
# sram_ctrl_sync

Clocked controller for external asynchronous SRAM, replacing direct combinational pass-through of the SRAM pins with a registered req/ack interface. It sequences read and write cycles with programmable strobe widths, write setup/hold, and guaranteed bus turnaround. It sits between core-side memory clients (CPU/video arbiters) and the Pocket SRAM pins. All SRAM outputs are registered.

## Interface
Parameters:
- AW, 17, address width in words
- DW, 16, data width; multiple of 8
- BW, DW/8, byte lanes (derived; do not override)
- RD_WAIT, 2, cycles OE is held low per read; at least 1
- WR_WAIT, 2, cycles WE is held low per write; at least 1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request; sampled only when ready=1
- we  in  1  1 = write, 0 = read; captured with req
- addr  in  AW  word address; captured with req
- din  in  DW  write data; captured with req
- be  in  BW  byte enables, active high, bit i = byte lane i; captured with req
- ready  out  1  controller idle, will accept req this cycle
- ack  out  1  one-cycle pulse: read data valid / write complete
- dout  out  DW  last read data; held until next read completes
- sram_addr  out  AW  SRAM address
- sram_dq  inout  DW  SRAM data; driven only during write states, else Z
- sram_we_n  out  1  SRAM write enable, active low
- sram_oe_n  out  1  SRAM output enable, active low
- sram_be_n  out  BW  SRAM byte masks, active low (16-bit: [1]=UB, [0]=LB)

## Operation
- States: IDLE, RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD. Down-counter sized clog2(max(RD_WAIT,WR_WAIT)+1).
- ready = (state==IDLE) & ~reset. Acceptance = req & ready at a rising edge; addr/we/din/be registered then. Client holds req and fields stable until accepted; req while ready=0 is ignored (no queueing).
- IDLE -> RD_STROBE (we=0) or WR_SETUP (we=1) on acceptance.
- RD_STROBE: sram_oe_n=0, sram_be_n all 0 (reads all lanes regardless of be), sram_we_n=1, dq Z; after RD_WAIT cycles sram_dq latched into dout, ack=1 next cycle, state -> IDLE.
- WR_SETUP (1 cycle): addr, dq=din, sram_be_n=~be driven; we_n=1, oe_n=1. -> WR_PULSE.
- WR_PULSE: sram_we_n=0 for WR_WAIT cycles; addr/data/be stable. -> WR_HOLD.
- WR_HOLD (1 cycle): sram_we_n=1, data still driven, ack=1. -> IDLE.
- be=0 on write: full cycle still executed, ack returned, no lanes written.
- sram_oe_n and sram_we_n never both 0. Data driven only in WR_* states; oe_n is high for ≥1 full cycle before any write drives dq.
- In IDLE: oe_n=1, we_n=1, be_n all 1, dq Z, sram_addr holds last value.
- Reset (any state, including mid-strobe): next edge forces IDLE, no ack for the aborted op, dout unchanged except cleared to 0; SRAM pins to idle values. Write in progress may be corrupted; not signalled.

## Timing
- Cycle 0 = acceptance cycle. Reset values: ready=0 during reset, 1 the cycle after; ack=0, dout=0, sram_addr=0, sram_we_n=1, sram_oe_n=1, sram_be_n all 1, sram_dq Z.
- Read: sram_addr valid and oe_n=0 in cycles 1..RD_WAIT; sampled at edge ending cycle RD_WAIT; ack=1, dout valid, ready=1 in cycle RD_WAIT+1. Throughput RD_WAIT+1 cycles/read back-to-back.
- Write: setup cycle 1; we_n=0 cycles 2..WR_WAIT+1; hold + ack in cycle WR_WAIT+2; ready=1 in cycle WR_WAIT+3. Throughput WR_WAIT+3 cycles/write.
- Read->write: new write accepted in read's ack cycle drives dq from the following cycle, oe_n already high one cycle earlier.
- SRAM access time must be ≤ RD_WAIT clk periods minus pad/board delay; WE pulse ≥ WR_WAIT periods.

## Test plan
- RD_WAIT=2: SRAM model holds 0xBEEF at 0x1234; read -> oe_n low cycles 1-2, ack and dout=0xBEEF in cycle 3, ready=1 cycle 3.
- WR_WAIT=2: write 0xA55A to 0x0010, be=2'b11 -> setup cycle 1, we_n low cycles 2-3, ack cycle 4, ready cycle 5; readback 0xA55A.
- Byte lanes: 0x0010 holds 0xA55A; write 0x1234 be=2'b01 -> readback 0xA534; be=2'b00 -> ack, readback unchanged.
- Back-to-back read then write accepted in read ack cycle -> oe_n and we_n never both low, dq Z until write setup, no X contention in model.
- req held while busy -> accepted only when ready=1, exactly one ack per accepted request, fields changing while busy ignored.
- Reset asserted in cycle 2 of a write -> next cycle we_n=1, dq Z, no ack, dout=0, ready=1 the cycle after reset drops.
